// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and address type for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-register write resolution: the highest-indexed port targeting a register wins.
// Purely combinational; wr_hit is the per-register write enable and the bypass hit mask.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NWR      = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [NREGS-1:0]    wr_hit,
  output logic [XLEN-1:0]     wr_sel_data [NREGS]
);

  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_sel_data[r] = '0;
      // Ascending port order lets the highest matching port overwrite lower ones.
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r]      = 1'b1;
          wr_sel_data[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0]      = 1'b0;
      wr_sel_data[0] = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard; zero-latency reads, writes on rising edge.
// Optional same-cycle write-to-read forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic                busy_any
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_sel_data [NREGS];
  logic             alloc_ok;
  logic [AW-1:0]    ra;

  regfile_wr_arbiter #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arbiter (
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_hit      (wr_hit),
    .wr_sel_data (wr_sel_data)
  );

  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Allocation beats a same-cycle write: the newly issued producer is still pending.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = wr_hit[r] ? wr_sel_data[r] : regs_q[r];
      if (alloc_ok && (alloc_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra                       = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN]  = regs_q[ra];
      rd_busy[i]               = busy_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_hit[ra]) begin
        rd_data[i*XLEN +: XLEN] = wr_sel_data[ra];
        if (!(alloc_ok && (alloc_addr == ra))) begin
          rd_busy[i] = 1'b0;
        end
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[i*XLEN +: XLEN] = '0;
      end
    end
  end

  assign busy_any = |busy_q;

endmodule
